// File: rtl/iic_arbiter_pkg.sv
// rtl/iic_arbiter_pkg.sv - shared iic definitions: FSM encodings, bus widths, default timing, arbitration helper
package iic_arbiter_pkg;

    localparam int IIC_ADDR_W      = 16;
    localparam int IIC_DATA_W      = 8;
    localparam int IIC_START_HOLD  = 50;
    localparam int IIC_TIMEOUT_CYC = 500_000;

    typedef enum logic [1:0] {
        ST_IDLE     = 2'd0,
        ST_START    = 2'd1,
        ST_WAIT_END = 2'd2,
        ST_DONE     = 2'd3
    } iic_state_e;

    // Returns the requester index to serve; a tie goes to the side not served last.
    function automatic logic arb_pick(input logic req0, input logic req1, input logic last_gnt);
        if (req0 && req1) begin
            return ~last_gnt;
        end
        return req0 ? 1'b0 : 1'b1;
    endfunction

endpackage

// File: rtl/iic_arbiter_end_sync.sv
// rtl/iic_arbiter_end_sync.sv - iic_end_sync: 2-flop synchroniser with rising-edge pulse for iic_clk->sys_clk levels
module iic_end_sync (
    input  logic clk,
    input  logic rst_n,
    input  logic i_async,
    output logic o_rise
);

    logic r_meta;
    logic r_sync;
    logic r_prev;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_meta <= 1'b0;
            r_sync <= 1'b0;
            r_prev <= 1'b0;
        end else begin
            r_meta <= i_async;
            r_sync <= r_meta;
            r_prev <= r_sync;
        end
    end

    assign o_rise = r_sync & ~r_prev;

endmodule

// File: rtl/iic_arbiter.sv
// rtl/iic_arbiter.sv - round-robin share of iic_control between m0 and m1
// Optional IIC_TIMEOUT_EN: abort WAIT_END after TIMEOUT_CYC cycles and flag mX_err.
module iic_arbiter
    import iic_arbiter_pkg::*;
#(
    parameter int START_HOLD  = IIC_START_HOLD,
    parameter int TIMEOUT_CYC = IIC_TIMEOUT_CYC
) (
    input  logic                  sys_clk,
    input  logic                  sys_rstn,
    input  logic                  m0_req,
    input  logic                  m0_wr,
    input  logic [IIC_ADDR_W-1:0] m0_addr,
    input  logic [IIC_DATA_W-1:0] m0_wdata,
    output logic                  m0_gnt,
    output logic                  m0_done,
    output logic [IIC_DATA_W-1:0] m0_rdata,
    output logic                  m0_err,
    input  logic                  m1_req,
    input  logic                  m1_wr,
    input  logic [IIC_ADDR_W-1:0] m1_addr,
    input  logic [IIC_DATA_W-1:0] m1_wdata,
    output logic                  m1_gnt,
    output logic                  m1_done,
    output logic [IIC_DATA_W-1:0] m1_rdata,
    output logic                  m1_err,
    input  logic                  iic_end,
    input  logic [IIC_DATA_W-1:0] rd_data,
    output logic                  wr_en,
    output logic                  rd_en,
    output logic                  iic_start,
    output logic [IIC_ADDR_W-1:0] byte_addr,
    output logic [IIC_DATA_W-1:0] wr_data
);

    localparam int CNT_MAX = (START_HOLD > TIMEOUT_CYC) ? START_HOLD : TIMEOUT_CYC;
    localparam int CNT_W   = $clog2(CNT_MAX + 1);
    localparam logic [CNT_W-1:0] HOLD_LAST = CNT_W'(START_HOLD - 1);

    iic_state_e            r_state;
    iic_state_e            w_next;
    logic                  r_pick_v;
    logic                  r_pick;
    logic                  r_sel;
    logic                  r_last_gnt;
    logic                  r_gnt;
    logic [CNT_W-1:0]      r_cnt;
    logic                  r_wr_en;
    logic                  r_rd_en;
    logic                  r_iic_start;
    logic [IIC_ADDR_W-1:0] r_byte_addr;
    logic [IIC_DATA_W-1:0] r_wr_data;
    logic [IIC_DATA_W-1:0] r_m0_rdata;
    logic [IIC_DATA_W-1:0] r_m1_rdata;
    logic                  w_end_pulse;
    logic                  w_hold_end;
    logic                  w_done;

    iic_end_sync u_end_sync (
        .clk     (sys_clk),
        .rst_n   (sys_rstn),
        .i_async (iic_end),
        .o_rise  (w_end_pulse)
    );

    assign w_hold_end = (r_cnt == HOLD_LAST);

`ifdef IIC_TIMEOUT_EN
    localparam logic [CNT_W-1:0] TO_LAST = CNT_W'(TIMEOUT_CYC - 1);
    logic r_err;
    logic w_timeout;
    assign w_timeout = (r_cnt == TO_LAST);
`endif

    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_state <= ST_IDLE;
        end else begin
            r_state <= w_next;
        end
    end

    always_comb begin
        w_next = r_state;
        case (r_state)
            ST_IDLE:     if (r_pick_v) w_next = ST_START;
            ST_START:    if (w_hold_end) w_next = ST_WAIT_END;
`ifdef IIC_TIMEOUT_EN
            ST_WAIT_END: if (w_end_pulse || w_timeout) w_next = ST_DONE;
`else
            ST_WAIT_END: if (w_end_pulse) w_next = ST_DONE;
`endif
            ST_DONE:     w_next = ST_IDLE;
            default:     w_next = ST_IDLE;
        endcase
    end

    // Arbitration decision is registered one cycle before the command is latched.
    always_ff @(posedge sys_clk or negedge sys_rstn) begin
        if (!sys_rstn) begin
            r_pick_v    <= 1'b0;
            r_pick      <= 1'b0;
            r_sel       <= 1'b0;
            r_last_gnt  <= 1'b1;
            r_gnt       <= 1'b0;
            r_cnt       <= '0;
            r_wr_en     <= 1'b0;
            r_rd_en     <= 1'b0;
            r_iic_start <= 1'b0;
            r_byte_addr <= '0;
            r_wr_data   <= '0;
            r_m0_rdata  <= '0;
            r_m1_rdata  <= '0;
`ifdef IIC_TIMEOUT_EN
            r_err       <= 1'b0;
`endif
        end else begin
            case (r_state)
                ST_IDLE: begin
                    if (r_pick_v) begin
                        r_pick_v    <= 1'b0;
                        r_sel       <= r_pick;
                        r_last_gnt  <= r_pick;
                        r_gnt       <= 1'b1;
                        r_byte_addr <= r_pick ? m1_addr : m0_addr;
                        r_wr_data   <= r_pick ? m1_wdata : m0_wdata;
                        r_wr_en     <= r_pick ? m1_wr : m0_wr;
                        r_rd_en     <= r_pick ? ~m1_wr : ~m0_wr;
                        r_iic_start <= 1'b1;
                        r_cnt       <= '0;
                    end else if (m0_req || m1_req) begin
                        r_pick_v <= 1'b1;
                        r_pick   <= arb_pick(m0_req, m1_req, r_last_gnt);
                    end
                end
                ST_START: begin
                    if (w_hold_end) begin
                        r_iic_start <= 1'b0;
                        r_cnt       <= '0;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
                end
                ST_WAIT_END: begin
                    if (w_end_pulse && r_rd_en) begin
                        if (r_sel) r_m1_rdata <= rd_data;
                        else       r_m0_rdata <= rd_data;
                    end
`ifdef IIC_TIMEOUT_EN
                    if (w_end_pulse) begin
                        r_err <= 1'b0;
                    end else if (w_timeout) begin
                        r_err <= 1'b1;
                    end else begin
                        r_cnt <= r_cnt + CNT_W'(1);
                    end
`endif
                end
                ST_DONE: begin
                    r_gnt   <= 1'b0;
                    r_wr_en <= 1'b0;
                    r_rd_en <= 1'b0;
                end
                default: begin
                    r_gnt <= 1'b0;
                end
            endcase
        end
    end

    assign w_done    = (r_state == ST_DONE);
    assign m0_done   = w_done & ~r_sel;
    assign m1_done   = w_done & r_sel;
    assign m0_gnt    = r_gnt & ~r_sel;
    assign m1_gnt    = r_gnt & r_sel;
    assign m0_rdata  = r_m0_rdata;
    assign m1_rdata  = r_m1_rdata;
    assign wr_en     = r_wr_en;
    assign rd_en     = r_rd_en;
    assign iic_start = r_iic_start;
    assign byte_addr = r_byte_addr;
    assign wr_data   = r_wr_data;

`ifdef IIC_TIMEOUT_EN
    assign m0_err = m0_done & r_err;
    assign m1_err = m1_done & r_err;
`else
    assign m0_err = 1'b0;
    assign m1_err = 1'b0;
`endif

endmodule

// File: tb/tb_iic_arbiter.sv
// tb/tb_iic_arbiter.sv - directed bench for iic_arbiter with a behavioural iic_control model
module tb_iic_arbiter;

    logic        sys_clk = 1'b0;
    logic        sys_rstn = 1'b0;
    logic        m0_req = 1'b0, m0_wr = 1'b0;
    logic [15:0] m0_addr = '0;
    logic [7:0]  m0_wdata = '0;
    logic        m0_gnt, m0_done, m0_err;
    logic [7:0]  m0_rdata;
    logic        m1_req = 1'b0, m1_wr = 1'b0;
    logic [15:0] m1_addr = '0;
    logic [7:0]  m1_wdata = '0;
    logic        m1_gnt, m1_done, m1_err;
    logic [7:0]  m1_rdata;
    logic        iic_end;
    logic [7:0]  rd_data;
    logic        wr_en, rd_en, iic_start;
    logic [15:0] byte_addr;
    logic [7:0]  wr_data;

    logic        model_en = 1'b1;
    int          model_n = 60;
    logic [7:0]  model_rdata = '0;
    logic        model_end = 1'b0;
    logic        spur_end = 1'b0;

    int          n_checks = 0;
    int          n_errors = 0;
    int          viol = 0;
    logic        in_txn = 1'b0;
    logic        prev_start = 1'b0;

    always #10 sys_clk = ~sys_clk;

    assign iic_end = model_end | spur_end;
    assign rd_data = model_rdata;

    iic_arbiter #(.START_HOLD(50), .TIMEOUT_CYC(1000)) dut (
        .sys_clk   (sys_clk),
        .sys_rstn  (sys_rstn),
        .m0_req    (m0_req),
        .m0_wr     (m0_wr),
        .m0_addr   (m0_addr),
        .m0_wdata  (m0_wdata),
        .m0_gnt    (m0_gnt),
        .m0_done   (m0_done),
        .m0_rdata  (m0_rdata),
        .m0_err    (m0_err),
        .m1_req    (m1_req),
        .m1_wr     (m1_wr),
        .m1_addr   (m1_addr),
        .m1_wdata  (m1_wdata),
        .m1_gnt    (m1_gnt),
        .m1_done   (m1_done),
        .m1_rdata  (m1_rdata),
        .m1_err    (m1_err),
        .iic_end   (iic_end),
        .rd_data   (rd_data),
        .wr_en     (wr_en),
        .rd_en     (rd_en),
        .iic_start (iic_start),
        .byte_addr (byte_addr),
        .wr_data   (wr_data)
    );

    // iic_control stand-in: raise iic_end model_n cycles after iic_start rises
    always begin
        @(posedge iic_start);
        if (model_en) begin
            repeat (model_n) @(negedge sys_clk);
            model_end = 1'b1;
            repeat (4) @(negedge sys_clk);
            model_end = 1'b0;
        end
    end

    always @(negedge sys_clk) begin
        if (!sys_rstn) begin
            in_txn <= 1'b0;
        end else begin
            if (m0_gnt && m1_gnt) viol <= viol + 1;
            if (iic_start && !prev_start && in_txn) viol <= viol + 1;
            if (m0_done || m1_done) in_txn <= 1'b0;
            else if (iic_start && !prev_start) in_txn <= 1'b1;
        end
        prev_start <= iic_start;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(negedge sys_clk);
    endtask

    task automatic measure_start(output int len);
        len = 0;
        while (iic_start && len < 200) begin
            len++;
            tick(1);
        end
    endtask

    task automatic wait_any_done(input int budget, output int who, output int cyc);
        who = -1;
        cyc = 0;
        while (cyc < budget) begin
            if (m0_done) begin who = 0; return; end
            if (m1_done) begin who = 1; return; end
            tick(1);
            cyc++;
        end
    endtask

    initial begin
        #2ms;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1);
    end

    initial begin
        int len, who, cyc, bad;
        int exp_order[3];
        exp_order[0] = 0;
        exp_order[1] = 1;
        exp_order[2] = 0;

        tick(3);
        check("rst_start", iic_start, 0);
        check("rst_gnt", {m0_gnt, m1_gnt}, 0);
        check("rst_en", {wr_en, rd_en}, 0);
        check("rst_addr", byte_addr, 0);
        sys_rstn = 1'b1;
        tick(2);

        // m0 read
        m0_wr = 1'b0; m0_addr = 16'h0002; model_rdata = 8'h45; m0_req = 1'b1;
        tick(1);
        check("t1_start_early", iic_start, 0);
        tick(1);
        check("t1_start_rise", iic_start, 1);
        check("t1_gnt", {m0_gnt, m1_gnt}, 2'b10);
        check("t1_rd_wr", {rd_en, wr_en}, 2'b10);
        check("t1_addr", byte_addr, 16'h0002);
        measure_start(len);
        check("t1_start_len", len, 50);
        wait_any_done(100, who, cyc);
        check("t1_done_who", who, 0);
        check("t1_done_lat", cyc, 12);
        check("t1_rdata", m0_rdata, 8'h45);
        check("t1_err", m0_err, 0);
        check("t1_gnt_at_done", m0_gnt, 1);
        m0_req = 1'b0;
        tick(1);
        check("t1_after_done", {m0_done, m0_gnt, rd_en}, 0);

        // spurious iic_end while idle
        spur_end = 1'b1;
        tick(4);
        spur_end = 1'b0;
        bad = 0;
        for (int i = 0; i < 12; i++) begin
            if (m0_done || m1_done || iic_start || m0_gnt || m1_gnt) bad++;
            tick(1);
        end
        check("t6_idle_quiet", bad, 0);

        // m1 write
        m1_wr = 1'b1; m1_addr = 16'h0010; m1_wdata = 8'hA5; model_rdata = 8'h3C; m1_req = 1'b1;
        tick(2);
        check("t3_start_rise", iic_start, 1);
        check("t3_gnt", {m0_gnt, m1_gnt}, 2'b01);
        check("t3_rd_wr", {rd_en, wr_en}, 2'b01);
        check("t3_addr", byte_addr, 16'h0010);
        measure_start(len);
        check("t3_start_len", len, 50);
        tick(5);
        check("t3_wait_wr_en", wr_en, 1);
        check("t3_wait_wr_data", wr_data, 8'hA5);
        wait_any_done(100, who, cyc);
        check("t3_done_who", who, 1);
        check("t3_done_lat", cyc, 7);
        check("t3_rdata_kept", m1_rdata, 8'h00);
        check("t3_err", m1_err, 0);
        m1_req = 1'b0;
        tick(1);

        // simultaneous requests, both held
        m0_wr = 1'b0; m0_addr = 16'h0100;
        m1_wr = 1'b0; m1_addr = 16'h0200;
        model_rdata = 8'h5A;
        m0_req = 1'b1; m1_req = 1'b1;
        for (int k = 0; k < 3; k++) begin
            wait_any_done(200, who, cyc);
            check("t2_order", who, exp_order[k]);
            check("t2_addr", byte_addr, (exp_order[k] == 1) ? 16'h0200 : 16'h0100);
            if (k == 2) begin
                m0_req = 1'b0;
                m1_req = 1'b0;
            end
            tick(1);
        end
        check("t2_no_overlap", viol, 0);
        check("t2_m0_rdata", m0_rdata, 8'h5A);
        check("t2_m1_rdata", m1_rdata, 8'h5A);

        // reset during WAIT_END with m1 pending
        model_en = 1'b0;
        m0_addr = 16'h0300; m0_req = 1'b1;
        tick(1);
        m1_addr = 16'h0040; m1_req = 1'b1;
        tick(71);
        check("t4_in_wait", {m0_gnt, rd_en, iic_start}, 3'b110);
        sys_rstn = 1'b0;
        #1;
        check("t4_rst_gnt", {m0_gnt, m1_gnt}, 0);
        check("t4_rst_en", {wr_en, rd_en, iic_start}, 0);
        check("t4_rst_addr", byte_addr, 0);
        check("t4_rst_rdata", {m0_rdata, m1_rdata}, 0);
        m0_req = 1'b0;
        model_en = 1'b1;
        model_rdata = 8'h77;
        tick(20);
        sys_rstn = 1'b1;
        tick(2);
        check("t4_m1_first", {m0_gnt, m1_gnt, iic_start}, 3'b011);
        check("t4_addr", byte_addr, 16'h0040);
        wait_any_done(200, who, cyc);
        check("t4_done_who", who, 1);
        check("t4_rdata", m1_rdata, 8'h77);
        m1_req = 1'b0;
        tick(1);

`ifdef IIC_TIMEOUT_EN
        // model never ends: abort after TIMEOUT_CYC cycles in WAIT_END
        model_en = 1'b0;
        m0_addr = 16'h0500; m0_req = 1'b1;
        tick(2);
        measure_start(len);
        check("t5_start_len", len, 50);
        wait_any_done(1200, who, cyc);
        check("t5_done_who", who, 0);
        check("t5_timeout_lat", cyc, 1000);
        check("t5_err", m0_err, 1);
        check("t5_rdata_kept", m0_rdata, 8'h00);
        m0_req = 1'b0;
        tick(1);
        model_en = 1'b1;
        model_rdata = 8'h99;
        m0_req = 1'b1;
        wait_any_done(200, who, cyc);
        check("t5_next_who", who, 0);
        check("t5_next_err", m0_err, 0);
        check("t5_next_rdata", m0_rdata, 8'h99);
        m0_req = 1'b0;
        tick(1);
`endif

        tick(2);
        check("final_no_overlap", viol, 0);
        $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
        $finish;
    end

endmodule
